// File: rtl/audioqsys_led_fader.sv
// Nine-channel LED fader: a channel request snaps brightness to full, then it
// decays one step per DECAY_TICKS base ticks, rendered as a 16-slot PWM.
module audioqsys_led_fader #(
    parameter int PRESCALE    = 50000,
    parameter int DECAY_TICKS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [8:0] pattern_in,
    output logic [8:0] led_out
);

    localparam int PW = $clog2(PRESCALE);
    localparam int DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_TICKS - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic [3:0]        pwm_q, pwm_d;
    logic [8:0][3:0]   bright_q, bright_d;
    logic [8:0]        led_q, led_d;
    logic              tick;
    logic              decay_strobe;

    assign tick         = (presc_q == PRESC_LAST);
    assign decay_strobe = tick && (dcnt_q == DECAY_LAST);

    always_comb begin
        presc_d  = tick ? '0 : presc_q + 1'b1;
        dcnt_d   = dcnt_q;
        pwm_d    = pwm_q + 4'd1;
        bright_d = bright_q;
        led_d    = '0;

        if (tick) begin
            dcnt_d = decay_strobe ? '0 : dcnt_q + 1'b1;
        end

        for (int i = 0; i < 9; i++) begin
            // Pre-edge brightness and PWM phase set this edge's LED level.
            led_d[i] = (bright_q[i] != 4'd0) && (pwm_q <= bright_q[i]);
            if (pattern_in[i]) begin
                bright_d[i] = 4'd15;
            end else if (decay_strobe && (bright_q[i] != 4'd0)) begin
                bright_d[i] = bright_q[i] - 4'd1;
            end
        end

        if (!enable) begin
            presc_d  = '0;
            dcnt_d   = '0;
            pwm_d    = '0;
            bright_d = '0;
            led_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q  <= '0;
            dcnt_q   <= '0;
            pwm_q    <= '0;
            bright_q <= '0;
            led_q    <= '0;
        end else begin
            presc_q  <= presc_d;
            dcnt_q   <= dcnt_d;
            pwm_q    <= pwm_d;
            bright_q <= bright_d;
            led_q    <= led_d;
        end
    end

    assign led_out = led_q;

endmodule

// File: tb/tb_audioqsys_led_fader.sv
// Bench for audioqsys_led_fader: directed boundary sequences plus random
// requests, enables and async resets against a time-based brightness model.
module tb_audioqsys_led_fader;

    localparam int P = 4;
    localparam int D = 2;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [8:0] pattern_in;
    logic [8:0] led_out;

    int         total;
    int         bad;

    // Model: t counts enabled edges since the last clear; everything shared
    // (PWM phase, tick, strobe) follows from t by plain arithmetic.
    int         t;
    int         mb [9];
    logic [8:0] exp_led;

    audioqsys_led_fader #(.PRESCALE(P), .DECAY_TICKS(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pattern_in (pattern_in),
        .led_out    (led_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0d got=%03h want=%03h at %0t", tag, t, got, want, $time);
        end
    endtask

    task automatic model_clear();
        t = 0;
        exp_led = '0;
        for (int i = 0; i < 9; i++) mb[i] = 0;
    endtask

    task automatic model_edge(input logic en, input logic [8:0] pat);
        int  pw;
        bit  strobe;
        if (reset || !en) begin
            model_clear();
        end else begin
            pw = t % 16;
            strobe = ((t % P) == P - 1) && (((t / P) % D) == D - 1);
            for (int i = 0; i < 9; i++) begin
                exp_led[i] = (mb[i] != 0) && (pw <= mb[i]);
                if (pat[i]) mb[i] = 15;
                else if (strobe && mb[i] > 0) mb[i] = mb[i] - 1;
            end
            t++;
        end
    endtask

    task automatic step(input logic en, input logic [8:0] pat);
        enable = en;
        pattern_in = pat;
        @(posedge clk);
        model_edge(en, pat);
        #1 chk("model", led_out, exp_led);
    endtask

    task automatic async_pulse();
        #1 reset = 1'b1;
        #1 chk("async_led", led_out, 9'h000);
        #2 reset = 1'b0;
        model_clear();
    endtask

    initial begin
        int last_lit;
        total = 0;
        bad = 0;
        model_clear();
        reset = 1'b1;
        enable = 1'b0;
        pattern_in = '0;
        repeat (3) @(posedge clk);
        #1 chk("reset_led", led_out, 9'h000);
        #3 reset = 1'b0;

        // Step response: lit from the second edge on, held steady.
        step(1'b1, 9'h001);
        chk("step_edge0", led_out, 9'h000);
        for (int k = 1; k < 20; k++) begin
            step(1'b1, 9'h001);
            chk("step_hold", led_out, 9'h001);
        end

        // Blank with all requests high, then one request and a full fade.
        step(1'b0, 9'h1FF);
        chk("blank", led_out, 9'h000);
        step(1'b1, 9'h001);
        last_lit = -1;
        for (int k = 1; k < 160; k++) begin
            step(1'b1, 9'h000);
            if (led_out[0]) last_lit = k;
            if (k == 113) chk("fade_last_lit", led_out, 9'h001);
            if (k >= 120) chk("fade_dark", led_out, 9'h000);
        end
        chk("fade_last_idx", 9'(last_lit), 9'd113);

        // Request coincident with the first decay strobe (t=7) must give 15.
        step(1'b0, 9'h000);
        for (int k = 0; k < 16; k++) begin
            step(1'b1, (k == 7) ? 9'h020 : 9'h000);
            if (k >= 8) chk("collide", led_out, 9'h020);
        end

        // Mid-fade blank, then restart and an async reset between edges.
        for (int k = 0; k < 30; k++) step(1'b1, (k < 3) ? 9'h1FF : 9'h000);
        step(1'b0, 9'h1FF);
        chk("blank_mid", led_out, 9'h000);
        for (int k = 0; k < 12; k++) step(1'b1, (k == 0) ? 9'h0F0 : 9'h000);
        for (int k = 0; k < 4; k++) step(1'b1, 9'h1FF);
        chk("pre_async", led_out, 9'h1FF);
        async_pulse();
        for (int k = 0; k < 40; k++) step(1'b1, (k == 2) ? 9'h003 : 9'h000);

        // Random traffic: sparse requests, rare blanks and async resets.
        for (int k = 0; k < 4000; k++) begin
            logic [8:0] pat;
            logic       en;
            pat = '0;
            for (int i = 0; i < 9; i++) pat[i] = ($urandom_range(0, 24) == 0);
            en = ($urandom_range(0, 79) != 0);
            step(en, pat);
            if ($urandom_range(0, 299) == 0) async_pulse();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
